// File: rtl/run_sequencer.sv
// run_sequencer: top-level run scheduler for the Ising-machine core.
// Steps each run through initial-spin pre-program, a programmed-length
// anneal and capture of the final spin vector into the result RF, then
// advances run_counter until the programmed total is reached. RERUN replays
// the last completed run; RESET aborts to IDLE from any state.
//
// Optional feature (macro RUN_SEQ_PAUSE_EN): adds input i_pause, which
// freezes the anneal (FSM, anneal counter and anneal_en) while high in
// ANNEAL. The pause input is registered before use so that no
// combinational path runs from an input to an output.
module run_sequencer #(
  parameter int SPIN_W   = 50,
  parameter int CNT_W    = 8,
  parameter int ANNEAL_W = 16
) (
  input  logic                i_clk,
  input  logic                i_rstn,
`ifdef RUN_SEQ_PAUSE_EN
  input  logic                i_pause,
`endif
  input  logic                conf_sys_ctrl_reg_RUN,
  input  logic                conf_sys_ctrl_reg_RERUN,
  input  logic                conf_sys_ctrl_reg_RESET,
  input  logic [CNT_W-1:0]    conf_reg_total_run_count,
  input  logic [ANNEAL_W-1:0] conf_reg_anneal_cycles,
  input  logic                coefficient_rf_wr_done,
  input  logic                initial_spin_rf_wr_done,
  input  logic [SPIN_W-1:0]   spin_result,
  output logic [CNT_W-1:0]    run_counter,
  output logic                spin_load,
  output logic                anneal_en,
  output logic [6:0]          result_rf_a,
  output logic [SPIN_W-1:0]   result_rf_d,
  output logic                result_rf_web,
  output logic                busy,
  output logic                run_done,
  output logic [2:0]          seq_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_SETTLE  = 3'd2,
    S_ANNEAL  = 3'd3,
    S_CAPTURE = 3'd4,
    S_NEXT    = 3'd5,
    S_DONE    = 3'd6
  } state_e;

  localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);
  localparam logic [ANNEAL_W-1:0] ANNEAL_ONE = ANNEAL_W'(1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    run_counter_q, run_counter_d;
  logic                rerun_flag_q, rerun_flag_d;
  logic [ANNEAL_W-1:0] anneal_cnt_q, anneal_cnt_d;
  logic                run_in_q, rerun_in_q, reset_in_q;
  logic                web_q, web_d;
  logic [6:0]          addr_q, addr_d;
  logic [SPIN_W-1:0]   data_q, data_d;
  logic                anneal_stall;

  logic                run_edge, rerun_edge, reset_edge;
  logic [CNT_W-1:0]    run_idx;
  logic [CNT_W+6:0]    run_idx_ext;
  logic [CNT_W-1:0]    next_count;
  logic                start_ok;

  assign run_edge   = conf_sys_ctrl_reg_RUN   & ~run_in_q;
  assign rerun_edge = conf_sys_ctrl_reg_RERUN & ~rerun_in_q;
  assign reset_edge = conf_sys_ctrl_reg_RESET & ~reset_in_q;

  // Same index derivation as the initial-spin RF controller uses.
  assign run_idx     = rerun_flag_q ? (run_counter_q - CNT_ONE) : run_counter_q;
  assign run_idx_ext = (CNT_W + 7)'(run_idx);
  assign next_count  = run_counter_q + CNT_ONE;
  assign start_ok    = coefficient_rf_wr_done & initial_spin_rf_wr_done &
                       (conf_reg_total_run_count != '0);

`ifdef RUN_SEQ_PAUSE_EN
  logic pause_q;

  // Register the pause request; it only has an effect in ANNEAL.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) pause_q <= 1'b0;
    else         pause_q <= i_pause;
  end

  assign anneal_stall = pause_q;
`else
  assign anneal_stall = 1'b0;
`endif

  // State and datapath registers, plus one-deep history of the control bits.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q       <= S_IDLE;
      run_counter_q <= '0;
      rerun_flag_q  <= 1'b0;
      anneal_cnt_q  <= '0;
      run_in_q      <= 1'b0;
      rerun_in_q    <= 1'b0;
      reset_in_q    <= 1'b0;
      web_q         <= 1'b1;
      addr_q        <= '0;
      data_q        <= '0;
    end else begin
      state_q       <= state_d;
      run_counter_q <= run_counter_d;
      rerun_flag_q  <= rerun_flag_d;
      anneal_cnt_q  <= anneal_cnt_d;
      run_in_q      <= conf_sys_ctrl_reg_RUN;
      rerun_in_q    <= conf_sys_ctrl_reg_RERUN;
      reset_in_q    <= conf_sys_ctrl_reg_RESET;
      web_q         <= web_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
    end
  end

  // Next-state logic; the result RF write is staged from CAPTURE into a
  // register so the write port is driven by flops, not by spin_result.
  // NOTE: every signal gets a default before the case so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d       = state_q;
    run_counter_d = run_counter_q;
    rerun_flag_d  = rerun_flag_q;
    anneal_cnt_d  = anneal_cnt_q;
    web_d         = 1'b1;
    addr_d        = '0;
    data_d        = '0;

    if (reset_edge) begin
      state_d       = S_IDLE;
      run_counter_d = '0;
      rerun_flag_d  = 1'b0;
      anneal_cnt_d  = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (run_edge) begin
            if (start_ok) begin
              state_d       = S_LOAD;
              run_counter_d = '0;
              rerun_flag_d  = 1'b0;
            end
          end else if (rerun_edge && (run_counter_q != '0)) begin
            state_d      = S_LOAD;
            rerun_flag_d = 1'b1;
          end
        end
        S_LOAD: state_d = S_SETTLE;
        S_SETTLE: begin
          anneal_cnt_d = (conf_reg_anneal_cycles == '0) ? ANNEAL_ONE
                                                        : conf_reg_anneal_cycles;
          state_d      = S_ANNEAL;
        end
        S_ANNEAL: begin
          if (!anneal_stall) begin
            anneal_cnt_d = anneal_cnt_q - ANNEAL_ONE;
            if (anneal_cnt_q == ANNEAL_ONE) state_d = S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          web_d   = 1'b0;
          addr_d  = run_idx_ext[6:0];
          data_d  = spin_result;
          state_d = S_NEXT;
        end
        S_NEXT: begin
          if (rerun_flag_q) begin
            state_d = S_DONE;
          end else begin
            run_counter_d = next_count;
            state_d = (next_count >= conf_reg_total_run_count) ? S_DONE : S_LOAD;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign seq_state     = state_q;
  assign run_counter   = run_counter_q;
  assign spin_load     = (state_q == S_LOAD);
  assign anneal_en     = (state_q == S_ANNEAL) & ~anneal_stall;
  assign busy          = (state_q != S_IDLE) & (state_q != S_DONE);
  assign run_done      = (state_q == S_DONE);
  assign result_rf_web = web_q;
  assign result_rf_a   = addr_q;
  assign result_rf_d   = data_q;

endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer: directed self-checking bench for run_sequencer.
// A negedge monitor tallies spin_load pulses, anneal_en cycles and result RF
// writes; each scenario compares deltas of those tallies with hand-derived
// values. Define RUN_SEQ_PAUSE_EN to include the pause scenario.
module tb_run_sequencer;

  localparam int SPIN_W = 50;
  localparam int CNT_W = 8;
  localparam int ANNEAL_W = 16;

  logic                i_clk = 1'b0;
  logic                i_rstn = 1'b0;
  logic                pause = 1'b0;
  logic                run_in = 1'b0, rerun_in = 1'b0, reset_in = 1'b0;
  logic [CNT_W-1:0]    total = '0;
  logic [ANNEAL_W-1:0] anneal = '0;
  logic                coef_done = 1'b0, init_done = 1'b0;
  logic [SPIN_W-1:0]   spin = '0;

  logic [CNT_W-1:0]    run_counter;
  logic                spin_load, anneal_en, result_rf_web, busy, run_done;
  logic [6:0]          result_rf_a;
  logic [SPIN_W-1:0]   result_rf_d;
  logic [2:0]          seq_state;

  run_sequencer #(.SPIN_W(SPIN_W), .CNT_W(CNT_W), .ANNEAL_W(ANNEAL_W)) dut (
    .i_clk                    (i_clk),
    .i_rstn                   (i_rstn),
`ifdef RUN_SEQ_PAUSE_EN
    .i_pause                  (pause),
`endif
    .conf_sys_ctrl_reg_RUN    (run_in),
    .conf_sys_ctrl_reg_RERUN  (rerun_in),
    .conf_sys_ctrl_reg_RESET  (reset_in),
    .conf_reg_total_run_count (total),
    .conf_reg_anneal_cycles   (anneal),
    .coefficient_rf_wr_done   (coef_done),
    .initial_spin_rf_wr_done  (init_done),
    .spin_result              (spin),
    .run_counter              (run_counter),
    .spin_load                (spin_load),
    .anneal_en                (anneal_en),
    .result_rf_a              (result_rf_a),
    .result_rf_d              (result_rf_d),
    .result_rf_web            (result_rf_web),
    .busy                     (busy),
    .run_done                 (run_done),
    .seq_state                (seq_state)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_err = 0;

  // Monitor state, written only by the monitor process.
  int                cyc = 0;
  int                n_load = 0;
  int                n_anneal = 0;
  int                load_cyc[$];
  int                wr_cyc[$];
  logic [6:0]        wr_a[$];
  logic [SPIN_W-1:0] wr_d[$];

  always @(negedge i_clk) begin
    cyc <= cyc + 1;
    if (spin_load) begin
      n_load <= n_load + 1;
      load_cyc.push_back(cyc);
    end
    if (anneal_en) n_anneal <= n_anneal + 1;
    if (!result_rf_web) begin
      wr_cyc.push_back(cyc);
      wr_a.push_back(result_rf_a);
      wr_d.push_back(result_rf_d);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit
  // after the rising edge.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic wait_done(input string tag);
    int budget = 400;
    while (!run_done && budget > 0) begin
      tick();
      budget--;
    end
    check({tag, "_timeout"}, 64'(run_done), 64'd1);
    tick(); // let the negedge monitor catch up
  endtask

  int l0, a0, w0, lc0;

  task automatic snap();
    l0  = n_load;
    a0  = n_anneal;
    w0  = wr_a.size();
    lc0 = load_cyc.size();
  endtask

  initial begin
    tick(3);
    i_rstn = 1'b1;
    tick();

    // Reset state.
    check("rst_state", 64'(seq_state), 64'd0);
    check("rst_cnt",   64'(run_counter), 64'd0);
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_done",  64'(run_done), 64'd0);
    check("rst_web",   64'(result_rf_web), 64'd1);
    check("rst_a",     64'(result_rf_a), 64'd0);
    check("rst_d",     64'(result_rf_d), 64'd0);
    check("rst_load",  64'(spin_load), 64'd0);
    check("rst_ann",   64'(anneal_en), 64'd0);

    // Full sequence: total=3, anneal=4.
    total = 8'd3; anneal = 16'd4; coef_done = 1'b1; init_done = 1'b1;
    spin = 50'h2_AAAA_5555_1234;
    snap();
    run_in = 1'b1;
    tick();
    run_in = 1'b0;
    check("seq_first_state", 64'(seq_state), 64'd1);
    check("seq_first_busy",  64'(busy), 64'd1);
    wait_done("seq");
    check("seq_loads",  64'(n_load - l0), 64'd3);
    check("seq_anneal", 64'(n_anneal - a0), 64'd12);
    check("seq_nwr",    64'(wr_a.size() - w0), 64'd3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("seq_wr%0d_a", i), 64'(wr_a[w0+i]), 64'(i));
      check($sformatf("seq_wr%0d_d", i), 64'(wr_d[w0+i]), 64'h2_AAAA_5555_1234);
    end
    check("seq_span01", 64'(load_cyc[lc0+1] - load_cyc[lc0]), 64'd8);
    check("seq_span12", 64'(load_cyc[lc0+2] - load_cyc[lc0+1]), 64'd8);
    check("seq_cnt",    64'(run_counter), 64'd3);
    check("seq_done",   64'(run_done), 64'd1);
    check("seq_state",  64'(seq_state), 64'd6);

    // RERUN replays run index 2.
    spin = 50'h1_0F0F_F0F0_00FF;
    snap();
    rerun_in = 1'b1;
    tick();
    rerun_in = 1'b0;
    wait_done("rerun");
    check("rerun_loads", 64'(n_load - l0), 64'd1);
    check("rerun_nwr",   64'(wr_a.size() - w0), 64'd1);
    check("rerun_a",     64'(wr_a[w0]), 64'd2);
    check("rerun_d",     64'(wr_d[w0]), 64'h1_0F0F_F0F0_00FF);
    check("rerun_cnt",   64'(run_counter), 64'd3);
    check("rerun_done",  64'(run_done), 64'd1);

    // RESET from DONE, then rejected starts.
    reset_in = 1'b1;
    tick();
    reset_in = 1'b0;
    check("rstedge_state", 64'(seq_state), 64'd0);
    check("rstedge_cnt",   64'(run_counter), 64'd0);
    coef_done = 1'b0;
    run_in = 1'b1; tick(); run_in = 1'b0; tick(2);
    check("nocoef_state", 64'(seq_state), 64'd0);
    check("nocoef_busy",  64'(busy), 64'd0);
    coef_done = 1'b1; total = 8'd0;
    run_in = 1'b1; tick(); run_in = 1'b0; tick(2);
    check("tot0_state", 64'(seq_state), 64'd0);
    rerun_in = 1'b1; tick(); rerun_in = 1'b0; tick(2);
    check("rerun_cnt0_state", 64'(seq_state), 64'd0);

    // anneal=0 behaves as a single anneal cycle.
    total = 8'd1; anneal = 16'd0; spin = 50'h3_1111_2222_3333;
    snap();
    run_in = 1'b1; tick(); run_in = 1'b0;
    wait_done("ann0");
    check("ann0_anneal", 64'(n_anneal - a0), 64'd1);
    check("ann0_nwr",    64'(wr_a.size() - w0), 64'd1);
    check("ann0_a",      64'(wr_a[w0]), 64'd0);
    check("ann0_cnt",    64'(run_counter), 64'd1);

    // RUN and RERUN edges together: RUN wins, full 2-run sequence.
    total = 8'd2; anneal = 16'd2;
    snap();
    run_in = 1'b1; rerun_in = 1'b1; tick(); run_in = 1'b0; rerun_in = 1'b0;
    wait_done("both");
    check("both_nwr", 64'(wr_a.size() - w0), 64'd2);
    check("both_a0",  64'(wr_a[w0]), 64'd0);
    check("both_cnt", 64'(run_counter), 64'd2);

    // RESET edge in the middle of run 1's anneal.
    total = 8'd3; anneal = 16'd6;
    snap();
    run_in = 1'b1; tick(); run_in = 1'b0;
    begin
      int budget = 200;
      while (!(run_counter == 8'd1 && anneal_en) && budget > 0) begin
        tick();
        budget--;
      end
      check("abort_reach", 64'(run_counter == 8'd1 && anneal_en), 64'd1);
    end
    tick();
    reset_in = 1'b1; tick(); reset_in = 1'b0;
    check("abort_state", 64'(seq_state), 64'd0);
    check("abort_cnt",   64'(run_counter), 64'd0);
    check("abort_ann",   64'(anneal_en), 64'd0);
    check("abort_web",   64'(result_rf_web), 64'd1);
    tick(20);
    check("abort_nwr",   64'(wr_a.size() - w0), 64'd1);
    check("abort_idle",  64'(seq_state), 64'd0);

`ifdef RUN_SEQ_PAUSE_EN
    // Pause for 3 cycles mid-anneal: 5 anneal cycles, capture 3 cycles late.
    total = 8'd1; anneal = 16'd5;
    snap();
    run_in = 1'b1; tick(); run_in = 1'b0;
    begin
      int budget = 50;
      while (!anneal_en && budget > 0) begin
        tick();
        budget--;
      end
      check("pause_reach", 64'(anneal_en), 64'd1);
    end
    tick(2);
    pause = 1'b1; tick(3); pause = 1'b0;
    wait_done("pause");
    check("pause_anneal", 64'(n_anneal - a0), 64'd5);
    check("pause_nwr",    64'(wr_a.size() - w0), 64'd1);
    check("pause_delay",  64'(wr_cyc[w0] - load_cyc[lc0]), 64'd11);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
